// File: rtl/thread_sched_pkg.sv
// Shared types for the fetch thread scheduler: thread id width, per-thread state encoding.
// threadid_t is sized from NTHREADS_CFG; thread_sched's NTHREADS must match it.
package thread_sched_pkg;

  localparam int NTHREADS_MAX = 8;
  localparam int NTHREADS_CFG = 4;

  typedef logic [$clog2(NTHREADS_CFG)-1:0] threadid_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READY     = 2'd1,
    WAIT_MISS = 2'd2,
    HOLD      = 2'd3
  } thread_state_t;

endpackage

// File: rtl/thread_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping modulo N.
// N must be a power of two so the index addition wraps for free.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt,
  output logic         gnt_valid
);

  logic [W-1:0] idx;

  // Walk from farthest to nearest so the nearest requester overwrites the result.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = N; i >= 1; i--) begin
      idx = ptr + W'(i);
      if (req[idx]) begin
        gnt       = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_sched.sv
// Fine-grained fetch thread scheduler: per-thread state tracking plus registered round-robin grant.
// Optional performance counters are enabled with the THREAD_SCHED_PERF_EN macro.
//
// Handshake: sel_valid/sel_thread are a registered, unconditional grant; there is no ready
// back-pressure, and the grant reflects events sampled at the previous posedge.
module thread_sched
  import thread_sched_pkg::*;
#(
  parameter int NTHREADS    = NTHREADS_CFG,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NTHREADS-1:0] thread_en,
  input  logic                miss_valid,
  input  threadid_t           miss_thread,
  input  logic                fill_valid,
  input  threadid_t           fill_thread,
  input  logic                hz_stall,
  input  threadid_t           hz_thread,
  output logic                sel_valid,
  output threadid_t           sel_thread
`ifdef THREAD_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_idle_cycles,
  output logic [31:0]         perf_miss_cycles
`endif
);

  localparam logic [2:0] HOLD_INIT = 3'(HOLD_CYCLES);

  thread_state_t state_q [NTHREADS];
  thread_state_t state_d [NTHREADS];
  logic [2:0]    cnt_q   [NTHREADS];
  logic [2:0]    cnt_d   [NTHREADS];
  threadid_t     ptr_q;

  logic [NTHREADS-1:0] req;
  threadid_t           gnt;
  logic                gnt_valid;

  // Per-thread next state; the branch order inside each state encodes event priority.
  always_comb begin
    for (int t = 0; t < NTHREADS; t++) begin
      state_d[t] = state_q[t];
      cnt_d[t]   = cnt_q[t];
      if (!thread_en[t]) begin
        state_d[t] = IDLE;
        cnt_d[t]   = '0;
      end else begin
        case (state_q[t])
          IDLE: state_d[t] = READY;
          READY: begin
            if (miss_valid && miss_thread == threadid_t'(t)) begin
              state_d[t] = WAIT_MISS;
            end else if (hz_stall && hz_thread == threadid_t'(t)) begin
              state_d[t] = HOLD;
              cnt_d[t]   = HOLD_INIT;
            end
          end
          WAIT_MISS: begin
            // A miss in the same cycle as the fill keeps the thread waiting.
            if (!(miss_valid && miss_thread == threadid_t'(t)) &&
                fill_valid && fill_thread == threadid_t'(t)) begin
              state_d[t] = READY;
            end
          end
          HOLD: begin
            if (miss_valid && miss_thread == threadid_t'(t)) begin
              state_d[t] = WAIT_MISS;
              cnt_d[t]   = '0;
            end else if (cnt_q[t] <= 3'd1) begin
              state_d[t] = READY;
              cnt_d[t]   = '0;
            end else begin
              cnt_d[t] = cnt_q[t] - 3'd1;
            end
          end
          default: state_d[t] = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    req = '0;
    for (int t = 0; t < NTHREADS; t++) begin
      req[t] = (state_d[t] == READY);
    end
  end

  rr_arbiter #(.N(NTHREADS)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NTHREADS; t++) begin
        state_q[t] <= IDLE;
        cnt_q[t]   <= '0;
      end
      ptr_q      <= threadid_t'(NTHREADS - 1);
      sel_valid  <= 1'b0;
      sel_thread <= '0;
    end else begin
      for (int t = 0; t < NTHREADS; t++) begin
        state_q[t] <= state_d[t];
        cnt_q[t]   <= cnt_d[t];
      end
      sel_valid <= gnt_valid;
      // With no grant, sel_thread and the pointer keep their last values.
      if (gnt_valid) begin
        sel_thread <= gnt;
        ptr_q      <= gnt;
      end
    end
  end

`ifdef THREAD_SCHED_PERF_EN
  logic any_wait;

  always_comb begin
    any_wait = 1'b0;
    for (int t = 0; t < NTHREADS; t++) begin
      if (state_q[t] == WAIT_MISS) any_wait = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_idle_cycles <= '0;
      perf_miss_cycles <= '0;
    end else begin
      if (!sel_valid && (|thread_en) && perf_idle_cycles != '1) begin
        perf_idle_cycles <= perf_idle_cycles + 32'd1;
      end
      if (any_wait && perf_miss_cycles != '1) begin
        perf_miss_cycles <= perf_miss_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
